bcd_counter6: RTL and testbench
===============================

BCD_COUNTER6 -- requirements
Module: bcd_counter6

Interface
REQ-001 Parameter TICK_DIV, default 16666666, number of clk cycles per count step; legal range 1..2^25-1.
REQ-002 clk  input  1  system clock (50 MHz board clock); all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  count enable; 1 = prescaler runs and steps are applied, 0 = full hold.
REQ-005 up  input  1  count direction; 1 = increment, 0 = decrement; sampled on the step cycle.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  24  six BCD nibbles to load; [3:0] = digit 0 (least significant).
REQ-008 digits  output  24  six BCD nibbles, one per seven-segment decoder; [3:0] drives HEX0, [23:20] drives HEX5.
REQ-009 step  output  1  one-cycle pulse, high on the cycle after a count step is applied.
REQ-010 wrap  output  1  one-cycle pulse, high on the cycle after 999999->000000 (up) or 000000->999999 (down).

Function
REQ-011 Prescaler: 25-bit counter; counts 0..TICK_DIV-1 while en=1 and wraps to 0; a step occurs on the cycle it equals TICK_DIV-1.
REQ-012 en=0: prescaler, digits, step and wrap hold (step and wrap clear to 0); no step is lost or queued.
REQ-013 Up step: digit 0 +1; any digit at 9 goes to 0 and carries into the next digit; carry chain is combinational within one cycle.
REQ-014 Down step: digit 0 -1; any digit at 0 goes to 9 and borrows from the next digit.
REQ-015 Up from 999999 gives 000000 with wrap=1; down from 000000 gives 999999 with wrap=1; no other transition asserts wrap.
REQ-016 digits, step and wrap are registered; the new value is visible one clk after the step cycle.
REQ-017 load=1 (regardless of en): digits take load_val on the next edge, prescaler clears to 0, step=0, wrap=0.
REQ-018 load_val nibble >9 is clamped to 9 on load; internal digits are never outside 0..9.
REQ-019 load and step on the same cycle: load wins; the step is discarded.
REQ-020 up changing between steps affects only the next step; no glitch on digits.
REQ-021 TICK_DIV=1: a step on every enabled cycle.

Reset
REQ-022 rst=1 asynchronously forces prescaler=0, digits=24'h000000, step=0, wrap=0.
REQ-023 Reset mid-count: the partial prescaler count is discarded; the first step after rst deasserts comes TICK_DIV enabled cycles later.
REQ-024 Deassertion is synchronised externally; the block needs no reset synchroniser.

Configuration
REQ-025 Macro BCD_COUNTER6_LZB_EN enables leading-zero blanking on the digits output.
REQ-026 With the macro: every digit above the most significant non-zero digit is output as 4'hF (decoder shows blank); digit 0 is never blanked; the internal count is unaffected.
REQ-027 Without the macro: digits outputs the raw BCD count, with no blanking logic.

Verification (TICK_DIV=4 unless stated)
REQ-028 rst pulse mid-count with en=1 -> digits=000000, step=0 immediately; first step exactly 4 cycles after deassertion.
REQ-029 en=1, up=1, load 000998, run 2 steps -> 000999 then 001000; step pulses one cycle each, 4 cycles apart.
REQ-030 load 999999, up=1, one step -> 000000, wrap=1 for exactly one cycle; then up=0, one step -> 999999, wrap=1 again.
REQ-031 load asserted on the prescaler terminal cycle with load_val=24'h12FA34 -> digits=129934 (clamped), no step pulse; next step 4 cycles later.
REQ-032 en dropped for 10 cycles at prescaler=2 -> digits frozen; step resumes 2 enabled cycles after en returns.
REQ-033 BCD_COUNTER6_LZB_EN defined, load 000305 -> digits=24'hFF0305; load 000000 -> 24'hFFFFF0; undefined -> raw 000305.

Source files
------------

// File: rtl/bcd_counter6.sv
// bcd_counter6: six-digit BCD up/down counter driven by a prescaler.
// The prescaler counts enabled clk cycles. On its terminal cycle one count
// step is applied to the six BCD digits: +1 when up=1, -1 when up=0.
//
// Ports
//   clk      system clock; all state changes on its rising edge
//   rst      asynchronous active-high reset
//   en       1 = prescaler runs and steps are applied, 0 = full hold
//   up       count direction, sampled on the step cycle (1 = increment)
//   load     synchronous load strobe; has priority over en and over a step
//   load_val six BCD nibbles to load; nibbles above 9 are clamped to 9
//   digits   six BCD nibbles; [3:0] is digit 0 (HEX0)
//   step     one-cycle pulse on the cycle after a step is applied
//   wrap     one-cycle pulse after 999999->000000 or 000000->999999
//
// Optional feature: define BCD_COUNTER6_LZB_EN to enable leading-zero
// blanking on digits. Blanked digits are output as 4'hF, digit 0 is never
// blanked, and the internal count is not changed.

module bcd_counter6 #(
   parameter int unsigned TICK_DIV = 16666666
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up,
   input  logic        load,
   input  logic [23:0] load_val,
   output logic [23:0] digits,
   output logic        step,
   output logic        wrap
);

   localparam logic [24:0] TC = 25'(TICK_DIV - 1);

   logic [24:0] presc_q, presc_d;
   logic [23:0] digits_q, digits_d;
   logic        step_q, step_d;
   logic        wrap_q, wrap_d;

   logic        tick;
   logic [23:0] count_nxt;
   logic        roll;
   logic [23:0] load_clamped;

   assign tick = en && (presc_q == TC);

   // Ripple the carry or borrow through all six digits in a single cycle.
   // If it is still pending after digit 5, the whole count rolled over.
   always_comb begin
      logic       cy;
      logic [3:0] dig;
      cy        = 1'b1;
      count_nxt = digits_q;
      for (int i = 0; i < 6; i++) begin
         dig = digits_q[4*i +: 4];
         if (cy) begin
            if (up) begin
               if (dig >= 4'd9) begin
                  count_nxt[4*i +: 4] = 4'd0;
               end else begin
                  count_nxt[4*i +: 4] = dig + 4'd1;
                  cy = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  count_nxt[4*i +: 4] = 4'd9;
               end else begin
                  count_nxt[4*i +: 4] = dig - 4'd1;
                  cy = 1'b0;
               end
            end
         end
      end
      roll = cy;
   end

   always_comb begin
      load_clamped = load_val;
      for (int i = 0; i < 6; i++) begin
         if (load_val[4*i +: 4] > 4'd9) begin
            load_clamped[4*i +: 4] = 4'd9;
         end
      end
   end

   always_comb begin
      presc_d  = presc_q;
      digits_d = digits_q;
      step_d   = 1'b0;
      wrap_d   = 1'b0;
      if (load) begin
         // A load wins over a step that falls on the same cycle.
         presc_d  = '0;
         digits_d = load_clamped;
      end else if (en) begin
         if (tick) begin
            presc_d  = '0;
            digits_d = count_nxt;
            step_d   = 1'b1;
            wrap_d   = roll;
         end else begin
            presc_d = presc_q + 25'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q  <= '0;
         digits_q <= '0;
         step_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         digits_q <= digits_d;
         step_q   <= step_d;
         wrap_q   <= wrap_d;
      end
   end

`ifdef BCD_COUNTER6_LZB_EN
   // Scan from the top digit down. Zeros are blanked until the first
   // non-zero digit is reached.
   always_comb begin
      logic blank;
      blank  = 1'b1;
      digits = digits_q;
      for (int i = 5; i >= 1; i--) begin
         if (digits_q[4*i +: 4] != 4'd0) begin
            blank = 1'b0;
         end
         if (blank) begin
            digits[4*i +: 4] = 4'hF;
         end
      end
   end
`else
   assign digits = digits_q;
`endif

   assign step = step_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter6.sv
module tb_bcd_counter6;

   logic        clk;
   logic        rst;
   logic        en;
   logic        up;
   logic        load;
   logic [23:0] load_val;
   logic [23:0] digits;
   logic        step;
   logic        wrap;

   int total;
   int bad;
   int n;

   bcd_counter6 #(.TICK_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .digits   (digits),
      .step     (step),
      .wrap     (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Count cycles until step is seen. The count is bounded at 20 cycles.
   task automatic wait_step(output int cnt);
      cnt = 0;
      do begin
         cyc();
         cnt++;
      end while (step !== 1'b1 && cnt < 20);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      en       = 1'b0;
      up       = 1'b1;
      load     = 1'b0;
      load_val = '0;
      cyc();
      cyc();
      chk("reset_digits", 32'(digits), 32'h0);
      chk("reset_step", 32'(step), 32'h0);
      chk("reset_wrap", 32'(wrap), 32'h0);

      // First step comes 4 enabled cycles after reset is released.
      rst = 1'b0;
      en  = 1'b1;
      wait_step(n);
      chk("first_step_lat", 32'(n), 32'd4);
      chk("first_step_digits", 32'(digits), 32'h000001);
      cyc();
      chk("step_one_cycle", 32'(step), 32'h0);
      cyc();

      // Reset in the middle of a count.
      rst = 1'b1;
      #1;
      chk("midrst_digits", 32'(digits), 32'h0);
      chk("midrst_step", 32'(step), 32'h0);
      cyc();
      rst = 1'b0;
      wait_step(n);
      chk("midrst_step_lat", 32'(n), 32'd4);

      // Load 000998 and count up across the 999 -> 1000 carry.
      load     = 1'b1;
      load_val = 24'h000998;
      cyc();
      load = 1'b0;
      chk("load998", 32'(digits), 32'h000998);
      chk("load998_step", 32'(step), 32'h0);
      wait_step(n);
      chk("up1_lat", 32'(n), 32'd4);
      chk("up1_digits", 32'(digits), 32'h000999);
      wait_step(n);
      chk("up2_lat", 32'(n), 32'd4);
      chk("up2_digits", 32'(digits), 32'h001000);
      chk("up2_wrap", 32'(wrap), 32'h0);

      // Up wrap from 999999, then down wrap from 000000.
      load     = 1'b1;
      load_val = 24'h999999;
      cyc();
      load = 1'b0;
      wait_step(n);
      chk("upwrap_lat", 32'(n), 32'd4);
      chk("upwrap_digits", 32'(digits), 32'h000000);
      chk("upwrap_wrap", 32'(wrap), 32'h1);
      up = 1'b0;
      cyc();
      chk("upwrap_wrap_clr", 32'(wrap), 32'h0);
      wait_step(n);
      chk("dnwrap_lat", 32'(n), 32'd3);
      chk("dnwrap_digits", 32'(digits), 32'h999999);
      chk("dnwrap_wrap", 32'(wrap), 32'h1);

      // Load on the terminal cycle, with clamping of nibbles above 9.
      cyc();
      cyc();
      cyc();
      chk("pre_tc_step", 32'(step), 32'h0);
      load     = 1'b1;
      load_val = 24'h12FA34;
      cyc();
      load = 1'b0;
      chk("clamp_digits", 32'(digits), 32'h129934);
      chk("clamp_step", 32'(step), 32'h0);
      chk("clamp_wrap", 32'(wrap), 32'h0);
      wait_step(n);
      chk("after_load_lat", 32'(n), 32'd4);
      chk("after_load_digits", 32'(digits), 32'h129933);

      // Drop en at prescaler=2 and hold for 10 cycles.
      cyc();
      cyc();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("hold_digits", 32'(digits), 32'h129933);
         chk("hold_step", 32'(step), 32'h0);
      end
      en = 1'b1;
      wait_step(n);
      chk("resume_lat", 32'(n), 32'd2);
      chk("resume_digits", 32'(digits), 32'h129932);

      // Leading-zero blanking when enabled, raw digits otherwise.
      load     = 1'b1;
      load_val = 24'h000305;
      cyc();
      load = 1'b0;
`ifdef BCD_COUNTER6_LZB_EN
      chk("lzb_305", 32'(digits), 32'hFF0305);
`else
      chk("raw_305", 32'(digits), 32'h000305);
`endif
      load     = 1'b1;
      load_val = 24'h000000;
      cyc();
      load = 1'b0;
`ifdef BCD_COUNTER6_LZB_EN
      chk("lzb_zero", 32'(digits), 32'hFFFFF0);
`else
      chk("raw_zero", 32'(digits), 32'h000000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
